// File: rtl/filt_peak_ctrl.sv
// -----------------------------------------------------------------------------
// filt_peak_ctrl
//
// Sequencing controller for a trapezoidal shaping filter. It enables the
// filter and waits out the fill time before arming. Once armed, it watches the
// shaped output for a threshold crossing and captures the amplitude a fixed
// number of cycles later, in the flat top. Each captured pulse is time-stamped
// and offered as a single event on a valid/ready interface.
//
// Optional feature macro: FILT_PILEUP_REJECT_EN
//   When defined, a pulse whose output falls back to or below the threshold
//   before its capture point is aborted. The abort is counted in pileup_cnt.
//   When undefined, capture always happens and pileup_cnt is tied to zero.
//
// Parameters
//   WIDTH      filter output / threshold / amplitude width (two's complement)
//   TS_W       timestamp width
//   SETTLE_LEN cycles from filter enable to armed
//   PEAK_DLY   cycles from threshold crossing to amplitude capture (>=1)
//   HOLD_LEN   minimum dead cycles after a capture before re-arm (>=1)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start      one-cycle pulse: enable filter and begin the sequence
//   stop       one-cycle pulse: disable filter, return to OFF (highest priority)
//   filt_run   filter enable; 0 holds the filter cleared
//   filt_out   shaped filter output, signed
//   threshold  signed trigger level
//   ev_valid   event available
//   ev_ready   consumer accepts the event
//   ev_amp     captured amplitude
//   ev_time    timestamp of the threshold crossing
//   drop_cnt   events lost because the output slot was full (saturating)
//   pileup_cnt aborted pulses (saturating; zero when the feature is off)
//   busy       high in every state except OFF
// -----------------------------------------------------------------------------
module filt_peak_ctrl #(
  parameter int WIDTH      = 16,
  parameter int TS_W       = 32,
  parameter int SETTLE_LEN = 32,
  parameter int PEAK_DLY   = 12,
  parameter int HOLD_LEN   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  output logic                    filt_run,
  input  logic signed [WIDTH-1:0] filt_out,
  input  logic signed [WIDTH-1:0] threshold,
  output logic                    ev_valid,
  input  logic                    ev_ready,
  output logic signed [WIDTH-1:0] ev_amp,
  output logic [TS_W-1:0]         ev_time,
  output logic [15:0]             drop_cnt,
  output logic [15:0]             pileup_cnt,
  output logic                    busy
);

  // One shared down-counter serves settle, peak delay and hold; size it for
  // the longest of the three.
  localparam int MAX_A   = (SETTLE_LEN > PEAK_DLY) ? SETTLE_LEN : PEAK_DLY;
  localparam int MAX_LEN = (MAX_A > HOLD_LEN) ? MAX_A : HOLD_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_LEN - 1);
  localparam logic [CNT_W-1:0] PEAK_LD   = CNT_W'(PEAK_DLY - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [TS_W-1:0]  TS_ONE    = TS_W'(1);

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_ARMED    = 3'd2,
    ST_RISE     = 3'd3,
    ST_HOLD     = 3'd4,
    ST_WAIT_LOW = 3'd5
  } state_t;

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [TS_W-1:0]   ts_r;
  logic [TS_W-1:0]   cand_r;

  logic above_s;
  logic cnt_zero_s;
  logic start_s;
  logic capture_s;
  logic abort_s;
  logic accept_s;
  logic load_s;
  logic drop_s;

  // Saturating 16-bit increment used by the loss counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

  assign above_s    = (filt_out > threshold);
  assign cnt_zero_s = (cnt_r == '0);
  // A start only takes effect from OFF, and stop overrides it.
  assign start_s    = (state_r == ST_OFF) & start & ~stop;
  // Capture point of a pulse; stop in the same cycle cancels it.
  assign capture_s  = (state_r == ST_RISE) & cnt_zero_s & ~stop;
  assign accept_s   = ev_valid & ev_ready;
  // The slot may be refilled in the same cycle its old event is taken.
  assign load_s     = capture_s & (~ev_valid | ev_ready);
  assign drop_s     = capture_s & ev_valid & ~ev_ready;

`ifdef FILT_PILEUP_REJECT_EN
  // Output back at/below threshold before the capture point means a pile-up.
  assign abort_s = (state_r == ST_RISE) & ~cnt_zero_s & ~above_s & ~stop;
`else
  assign abort_s = 1'b0;
`endif

  // Sequencer: state, shared down-counter, crossing timestamp and run/busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_OFF;
      cnt_r    <= '0;
      cand_r   <= '0;
      filt_run <= 1'b0;
      busy     <= 1'b0;
    end else if (stop) begin
      state_r  <= ST_OFF;
      cnt_r    <= '0;
      filt_run <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state_r)
        ST_OFF: begin
          if (start) begin
            state_r  <= ST_SETTLE;
            cnt_r    <= SETTLE_LD;
            filt_run <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt_zero_s) begin
            state_r <= ST_ARMED;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_ARMED: begin
          if (above_s) begin
            state_r <= ST_RISE;
            cnt_r   <= PEAK_LD;
            cand_r  <= ts_r;
          end
        end
        ST_RISE: begin
          if (cnt_zero_s) begin
            state_r <= ST_HOLD;
            cnt_r   <= HOLD_LD;
          end else if (abort_s) begin
            state_r <= ST_ARMED;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_HOLD: begin
          if (cnt_zero_s) begin
            state_r <= ST_WAIT_LOW;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_WAIT_LOW: begin
          // Re-arm only once the current pulse has fallen away.
          if (!above_s) begin
            state_r <= ST_ARMED;
          end
        end
        default: begin
          state_r  <= ST_OFF;
          cnt_r    <= '0;
          filt_run <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // Free-running timestamp: cleared by a start, advances while busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_r <= '0;
    end else if (start_s) begin
      ts_r <= '0;
    end else if (busy) begin
      ts_r <= ts_r + TS_ONE;
    end else begin
      ts_r <= ts_r;
    end
  end

  // Single-entry event slot; survives stop, lost only on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ev_valid <= 1'b0;
      ev_amp   <= '0;
      ev_time  <= '0;
    end else if (load_s) begin
      ev_valid <= 1'b1;
      ev_amp   <= filt_out;
      ev_time  <= cand_r;
    end else if (accept_s) begin
      ev_valid <= 1'b0;
    end else begin
      ev_valid <= ev_valid;
    end
  end

  // Count of captures discarded because the slot was still occupied.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= 16'h0000;
    end else if (start_s) begin
      drop_cnt <= 16'h0000;
    end else if (drop_s) begin
      drop_cnt <= sat_inc(drop_cnt);
    end else begin
      drop_cnt <= drop_cnt;
    end
  end

`ifdef FILT_PILEUP_REJECT_EN
  // Count of pulses aborted as pile-up.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pileup_cnt <= 16'h0000;
    end else if (start_s) begin
      pileup_cnt <= 16'h0000;
    end else if (abort_s) begin
      pileup_cnt <= sat_inc(pileup_cnt);
    end else begin
      pileup_cnt <= pileup_cnt;
    end
  end
`else
  assign pileup_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_filt_peak_ctrl.sv
module tb_filt_peak_ctrl;

  localparam int WIDTH      = 16;
  localparam int TS_W       = 32;
  localparam int SETTLE_LEN = 32;
  localparam int PEAK_DLY   = 12;
  localparam int HOLD_LEN   = 8;

`ifdef FILT_PILEUP_REJECT_EN
  localparam bit PILEUP = 1'b1;
`else
  localparam bit PILEUP = 1'b0;
`endif

  logic                    clk;
  logic                    reset;
  logic                    start;
  logic                    stop;
  logic                    filt_run;
  logic signed [WIDTH-1:0] filt_out;
  logic signed [WIDTH-1:0] threshold;
  logic                    ev_valid;
  logic                    ev_ready;
  logic [WIDTH-1:0]        ev_amp;
  logic [TS_W-1:0]         ev_time;
  logic [15:0]             drop_cnt;
  logic [15:0]             pileup_cnt;
  logic                    busy;

  filt_peak_ctrl #(
    .WIDTH(WIDTH), .TS_W(TS_W), .SETTLE_LEN(SETTLE_LEN),
    .PEAK_DLY(PEAK_DLY), .HOLD_LEN(HOLD_LEN)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .filt_run(filt_run), .filt_out(filt_out), .threshold(threshold),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_amp(ev_amp),
    .ev_time(ev_time), .drop_cnt(drop_cnt), .pileup_cnt(pileup_cnt),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural model: phases with absolute-cycle deadlines.
  localparam int P_OFF = 0, P_SETTLE = 1, P_LOOK = 2, P_PULSE = 3, P_DEAD = 4, P_LOW = 5;
  int          m_phase;
  longint      n;
  longint      m_ready_edge, m_cap_edge, m_dead_until, m_start_edge;
  logic [31:0] m_cand;
  logic        m_valid;
  logic [15:0] m_amp;
  logic [31:0] m_time;
  logic [15:0] m_drop, m_pile;

  logic signed [15:0] cur_fo, cur_th;
  logic               cur_rdy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_OFF; m_valid = 1'b0; m_amp = 16'd0; m_time = 32'd0;
    m_drop = 16'd0; m_pile = 16'd0; m_cand = 32'd0;
  endtask

  task automatic model_step(input bit st, input bit sp, input logic signed [15:0] fo,
                            input logic signed [15:0] th, input bit rdy);
    bit          cap;
    logic [15:0] cap_amp;
    cap = 1'b0;
    cap_amp = 16'd0;
    n++;
    if (sp) begin
      m_phase = P_OFF;
    end else begin
      case (m_phase)
        P_OFF: if (st) begin
          m_phase = P_SETTLE; m_ready_edge = n + SETTLE_LEN; m_start_edge = n;
          m_drop = 16'd0; m_pile = 16'd0;
        end
        P_SETTLE: if (n == m_ready_edge) m_phase = P_LOOK;
        P_LOOK: if (fo > th) begin
          m_phase = P_PULSE; m_cap_edge = n + PEAK_DLY;
          m_cand = 32'(n - 1 - m_start_edge);
        end
        P_PULSE: begin
          if (n == m_cap_edge) begin
            cap = 1'b1; cap_amp = fo; m_dead_until = n + HOLD_LEN; m_phase = P_DEAD;
          end else if (PILEUP && (fo <= th)) begin
            if (m_pile != 16'hFFFF) m_pile = m_pile + 16'd1;
            m_phase = P_LOOK;
          end
        end
        P_DEAD: if (n == m_dead_until) m_phase = P_LOW;
        P_LOW: if (fo <= th) m_phase = P_LOOK;
        default: m_phase = P_OFF;
      endcase
    end
    if (cap && (!m_valid || rdy)) begin
      m_valid = 1'b1; m_amp = cap_amp; m_time = m_cand;
    end else begin
      if (cap && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      if (m_valid && rdy) m_valid = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".filt_run"},   64'(filt_run),   64'(m_phase != P_OFF));
    chk({tag, ".busy"},       64'(busy),       64'(m_phase != P_OFF));
    chk({tag, ".ev_valid"},   64'(ev_valid),   64'(m_valid));
    chk({tag, ".ev_amp"},     64'(ev_amp),     64'(m_amp));
    chk({tag, ".ev_time"},    64'(ev_time),    64'(m_time));
    chk({tag, ".drop_cnt"},   64'(drop_cnt),   64'(m_drop));
    chk({tag, ".pileup_cnt"}, 64'(pileup_cnt), 64'(m_pile));
  endtask

  // One clock: drive inputs, let the edge happen, advance model, compare.
  task automatic step(input bit st, input bit sp);
    start = st; stop = sp; filt_out = cur_fo; threshold = cur_th; ev_ready = cur_rdy;
    @(posedge clk);
    model_step(st, sp, cur_fo, cur_th, cur_rdy);
    @(negedge clk);
    check_all("cyc");
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0);
  endtask

  int lat;
  int seg;
  int v;

  initial begin
    n = 0;
    reset = 1'b1; start = 1'b0; stop = 1'b0; filt_out = 16'sd0; threshold = 16'sd0; ev_ready = 1'b0;
    cur_fo = 16'sd0; cur_th = 16'sd100; cur_rdy = 1'b0;
    model_reset();
    #3;
    check_all("reset");
    chk("reset.busy_lit", 64'(busy), 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    check_all("post_reset");

    // Settle: filt_out high long before arming; crossing only once armed.
    step(1'b1, 1'b0);
    steps(4);
    cur_fo = 16'sd500;
    lat = 0;
    while (!ev_valid && lat < 80) begin step(1'b0, 1'b0); lat++; end
    chk("settle.ev_valid", 64'(ev_valid), 64'd1);
    chk("settle.ev_time", 64'(ev_time), 64'd32);
    chk("settle.ev_amp", 64'(ev_amp), 64'd500);
    cur_rdy = 1'b1;
    step(1'b0, 1'b0);
    chk("settle.drain", 64'(ev_valid), 64'd0);
    cur_fo = 16'sd0;
    steps(12);

    // Single pulse with ready held high.
    cur_fo = 16'sd1000;
    step(1'b0, 1'b0);
    lat = 0;
    while (!ev_valid && lat < 40) begin step(1'b0, 1'b0); lat++; end
    chk("pulse.latency", 64'(lat), 64'(PEAK_DLY));
    chk("pulse.ev_amp", 64'(ev_amp), 64'd1000);
    steps(30);
    chk("pulse.no_retrig", 64'(ev_valid), 64'd0);

    // Backpressure: two pulses 40 cycles apart with ready low.
    cur_rdy = 1'b0; cur_fo = 16'sd0;
    steps(12);
    cur_fo = 16'sd1000; steps(20);
    cur_fo = 16'sd0;    steps(20);
    cur_fo = 16'sd800;  steps(20);
    cur_fo = 16'sd0;    steps(20);
    chk("bp.drop_cnt", 64'(drop_cnt), 64'd1);
    chk("bp.ev_amp", 64'(ev_amp), 64'd1000);
    chk("bp.ev_valid", 64'(ev_valid), 64'd1);
    cur_rdy = 1'b1;
    step(1'b0, 1'b0);
    chk("bp.release", 64'(ev_valid), 64'd0);

    // Pile-up: output sags to 50 from the fourth RISE cycle.
    cur_rdy = 1'b0;
    steps(3);
    cur_fo = 16'sd1000; step(1'b0, 1'b0);
    steps(3);
    cur_fo = 16'sd50;   steps(20);
    chk("pileup.cnt", 64'(pileup_cnt), PILEUP ? 64'd1 : 64'd0);
    chk("pileup.ev_valid", 64'(ev_valid), PILEUP ? 64'd0 : 64'd1);
    if (!PILEUP) chk("pileup.ev_amp", 64'(ev_amp), 64'd50);
    cur_rdy = 1'b1; steps(2);

    // stop during RISE while an event is pending.
    cur_rdy = 1'b0; cur_fo = 16'sd0; steps(10);
    cur_fo = 16'sd1000; steps(20);
    cur_fo = 16'sd0;    steps(12);
    cur_fo = 16'sd1000; steps(3);
    step(1'b0, 1'b1);
    chk("stop.filt_run", 64'(filt_run), 64'd0);
    chk("stop.busy", 64'(busy), 64'd0);
    chk("stop.pending", 64'(ev_valid), 64'd1);
    steps(5);
    chk("stop.retained", 64'(ev_valid), 64'd1);
    cur_rdy = 1'b1;
    step(1'b0, 1'b0);
    chk("stop.accepted", 64'(ev_valid), 64'd0);
    step(1'b1, 1'b1);
    chk("startstop.busy", 64'(busy), 64'd0);

    // Asynchronous reset during HOLD.
    cur_fo = 16'sd0;
    step(1'b1, 1'b0);
    steps(40);
    cur_fo = 16'sd1000;
    lat = 0;
    while (m_phase != P_DEAD && lat < 40) begin step(1'b0, 1'b0); lat++; end
    chk("areset.reach_hold", 64'(m_phase == P_DEAD), 64'd1);
    steps(2);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("areset");
    chk("areset.busy_lit", 64'(busy), 64'd0);
    chk("areset.ev_valid_lit", 64'(ev_valid), 64'd0);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic.
    seg = 0;
    for (int c = 0; c < 4000; c++) begin
      if (seg == 0) begin
        seg = int'($urandom_range(1, 30));
        v = int'($urandom_range(0, 4000));
        cur_fo = 16'(v - 1000);
        if ($urandom_range(0, 7) == 0) cur_fo = cur_th;
      end
      seg--;
      if ($urandom_range(0, 99) == 0) begin
        v = int'($urandom_range(0, 600));
        cur_th = 16'(v - 100);
      end
      cur_rdy = ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 99) < 3, $urandom_range(0, 999) < 3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
